hex_quiz_round_ctrl: RTL

Round engine for one quiz game. It starts when the game FSM's state code enters a difficulty state (3 = easy, 4 = medium, 5 = hard). It generates pseudo-random hex questions, times each answer, scores the player, and raises rem when the round is over. It sits directly upstream of the game FSM: rem feeds the FSM's rem input, and score is held for the leaderboard.

---
 rtl/hex_quiz_round_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hex_quiz_round_ctrl.sv
// hex_quiz_round_ctrl: per-round question engine for the hex quiz game.
// Draws questions from a free-running LFSR, counts down the answer time,
// judges the player's switch answer and flags round completion (o_rem).
module hex_quiz_round_ctrl #(
  parameter int          NUM_Q     = 10,
  parameter int          TICK_DIV  = 50_000_000,
  parameter int          EASY_SECS = 30,
  parameter int          MED_SECS  = 20,
  parameter int          HARD_SECS = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_state,
  input  logic       i_submit_n,
  input  logic [7:0] i_answer_sw,
  output logic [7:0] o_question,
  output logic [7:0] o_time_left,
  output logic [7:0] o_score,
  output logic [3:0] o_q_idx,
  output logic       o_round_active,
  output logic       o_correct_pulse,
  output logic       o_wrong_pulse,
  output logic       o_rem
);

  localparam int          TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]  LAST_Q     = 4'(NUM_Q - 1);
  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Q,
    S_ASK,
    S_JUDGE,
    S_DONE
  } state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_lfsr;
  logic [2:0]  r_sync;
  logic [7:0]  r_question, w_question_next;
  logic [7:0]  r_time_left, w_time_left_next;
  logic [7:0]  r_score, w_score_next;
  logic [3:0]  r_q_idx, w_q_idx_next;
  logic [TW-1:0] r_tick, w_tick_next;
  logic [7:0]  r_mask, w_mask_next;
  logic [7:0]  r_secs, w_secs_next;
  logic [7:0]  r_answer, w_answer_next;
  logic        r_timed_out, w_timed_out_next;
  logic        r_correct_pulse, w_correct_pulse_next;
  logic        r_wrong_pulse, w_wrong_pulse_next;

  logic        w_valid;
  logic [7:0]  w_mask_sel;
  logic [7:0]  w_secs_sel;
  logic        w_submit_pulse;
  logic        w_tick_wrap;
  logic        w_timeout;
  logic        w_correct;

  // Synchronizer chain for the button; idle level is 1 so reset to 1.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      // One stage of the submit_n synchronizer / edge-detect chain
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_sync[gi] <= 1'b1;
        end else if (gi == 0) begin
          r_sync[gi] <= i_submit_n;
        end else begin
          r_sync[gi] <= r_sync[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  // Falling edge after synchronisation: old level high, new level low.
  assign w_submit_pulse = r_sync[2] & ~r_sync[1];

  // Free-running question source, never reloaded outside reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign w_valid = (i_state == 3'd3) || (i_state == 3'd4) || (i_state == 3'd5);

  // Difficulty decode of the live game state (only latched in IDLE)
  always_comb begin
    w_mask_sel = 8'hFF;
    w_secs_sel = 8'(MED_SECS);
    case (i_state)
      3'd3:    begin w_mask_sel = 8'h0F; w_secs_sel = 8'(EASY_SECS); end
      3'd4:    begin w_mask_sel = 8'hFF; w_secs_sel = 8'(MED_SECS);  end
      3'd5:    begin w_mask_sel = 8'hFF; w_secs_sel = 8'(HARD_SECS); end
      default: begin w_mask_sel = 8'hFF; w_secs_sel = 8'(MED_SECS);  end
    endcase
  end

  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_timeout   = w_tick_wrap && (r_time_left == 8'd1);
  assign w_correct   = (r_answer == r_question) && !r_timed_out;

  // Next-state and datapath decisions; everything holds unless changed
  always_comb begin
    w_state_next         = r_state;
    w_question_next      = r_question;
    w_time_left_next     = r_time_left;
    w_score_next         = r_score;
    w_q_idx_next         = r_q_idx;
    w_tick_next          = r_tick;
    w_mask_next          = r_mask;
    w_secs_next          = r_secs;
    w_answer_next        = r_answer;
    w_timed_out_next     = r_timed_out;
    w_correct_pulse_next = 1'b0;
    w_wrong_pulse_next   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_score_next = 8'd0;
          w_q_idx_next = 4'd0;
          w_mask_next  = w_mask_sel;
          w_secs_next  = w_secs_sel;
          w_state_next = S_LOAD_Q;
        end
      end

      S_LOAD_Q: begin
        if (!w_valid) begin
          w_state_next = S_IDLE;
        end else begin
          w_question_next  = r_lfsr[7:0] & r_mask;
          w_time_left_next = r_secs;
          w_tick_next      = '0;
          w_state_next     = S_ASK;
        end
      end

      S_ASK: begin
        if (!w_valid) begin
          w_state_next = S_IDLE;
        end else begin
          if (w_tick_wrap) begin
            w_tick_next = '0;
            if (r_time_left != 8'd0) begin
              w_time_left_next = r_time_left - 8'd1;
            end
          end else begin
            w_tick_next = r_tick + TW'(1);
          end
          // A press in the timeout cycle still counts as an answer
          if (w_submit_pulse) begin
            w_answer_next    = i_answer_sw & r_mask;
            w_timed_out_next = 1'b0;
            w_state_next     = S_JUDGE;
          end else if (w_timeout) begin
            w_timed_out_next = 1'b1;
            w_state_next     = S_JUDGE;
          end
        end
      end

      S_JUDGE: begin
        if (!w_valid) begin
          w_state_next = S_IDLE;
        end else begin
          if (w_correct) begin
            w_score_next         = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            w_correct_pulse_next = 1'b1;
          end else begin
            w_wrong_pulse_next = 1'b1;
          end
          if (r_q_idx == LAST_Q) begin
            w_state_next = S_DONE;
          end else begin
            w_q_idx_next = r_q_idx + 4'd1;
            w_state_next = S_LOAD_Q;
          end
        end
      end

      S_DONE: begin
        if (!w_valid) begin
          w_state_next = S_IDLE;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // Control state and datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_question      <= 8'd0;
      r_time_left     <= 8'd0;
      r_score         <= 8'd0;
      r_q_idx         <= 4'd0;
      r_tick          <= '0;
      r_mask          <= 8'hFF;
      r_secs          <= 8'd0;
      r_answer        <= 8'd0;
      r_timed_out     <= 1'b0;
      r_correct_pulse <= 1'b0;
      r_wrong_pulse   <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_question      <= w_question_next;
      r_time_left     <= w_time_left_next;
      r_score         <= w_score_next;
      r_q_idx         <= w_q_idx_next;
      r_tick          <= w_tick_next;
      r_mask          <= w_mask_next;
      r_secs          <= w_secs_next;
      r_answer        <= w_answer_next;
      r_timed_out     <= w_timed_out_next;
      r_correct_pulse <= w_correct_pulse_next;
      r_wrong_pulse   <= w_wrong_pulse_next;
    end
  end

  assign o_question      = r_question;
  assign o_time_left     = r_time_left;
  assign o_score         = r_score;
  assign o_q_idx         = r_q_idx;
  assign o_round_active  = (r_state == S_ASK);
  assign o_rem           = (r_state == S_DONE);
  assign o_correct_pulse = r_correct_pulse;
  assign o_wrong_pulse   = r_wrong_pulse;

endmodule
